mips_regfile_fwd: RTL and testbench

Parametrised register file for the MIPS32 pipeline, replacing the ad-hoc `Reg` array, the one-level forwarding and the missing load-use handling in the core's ID stage. It provides:
- `NRD` combinational read ports, each with two-level operand forwarding (EX/MEM result, then WB write-through);
- a per-register load scoreboard that raises a load-use stall to the ID stage;
- a flush input that cancels pending loads on a taken branch or jump.

---
 rtl/mips_regfile_fwd.sv | 101 ++++++++++
 tb/tb_mips_regfile_fwd.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_fwd.sv
// MIPS32 ID-stage register file: forwarded read ports, a load-use scoreboard
// with stall generation, and flush of in-flight loads.
module mips_regfile_fwd #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                fwd_valid,
  input  logic [AW-1:0]       fwd_addr,
  input  logic [XLEN-1:0]     fwd_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                issue_valid,
  input  logic                issue_is_load,
  input  logic [AW-1:0]       issue_addr,
  input  logic                flush,
  output logic                stall,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;
  logic [NRD-1:0]  port_stall;
  logic            wr_ok;
  logic            issue_set;

  assign wr_ok     = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));
  assign issue_set = issue_valid && issue_is_load && !stall &&
                     !((ZERO_REG != 0) && (issue_addr == '0));

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_port
      logic [AW-1:0]   addr;
      logic            is_zero;
      logic            wb_hit;
      logic [XLEN-1:0] data;

      assign addr    = rd_addr[i*AW +: AW];
      assign is_zero = (ZERO_REG != 0) && (addr == '0);
      assign wb_hit  = wb_en && (wb_addr == addr);

      // EX/MEM result is newer than the write-back value, so it wins
      always_comb begin
        data = regs[addr];
        if (is_zero)                               data = '0;
        else if (fwd_valid && (fwd_addr == addr))  data = fwd_data;
        else if (wb_hit)                           data = wb_data;
      end

      assign rd_data[i*XLEN +: XLEN] = data;
      assign port_stall[i] = rd_en[i] && !is_zero && pend[addr] && !wb_hit;
    end
  endgenerate

  assign stall = |port_stall;

  // Set after clear so a new load to the register being written back stays pending
  always_comb begin
    pend_nxt = pend;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (wb_en)     pend_nxt[wb_addr]    = 1'b0;
      if (issue_set) pend_nxt[issue_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mips_regfile_fwd.sv
// Checks two configurations of mips_regfile_fwd (32x32/2 ports and 16x64/3 ports)
// against an array-based reference model using directed and random stimulus.
module tb_mips_regfile_fwd;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst, fwd_valid, wb_en, issue_valid, issue_is_load, flush;

  // Per-configuration stimulus: index 0 is the 32-bit DUT, index 1 the 64-bit DUT
  logic        st_rd_en   [2][4];
  logic [7:0]  st_rd_addr [2][4];
  logic [7:0]  st_fwd_addr[2];
  logic [7:0]  st_wb_addr [2];
  logic [7:0]  st_issue_addr[2];
  logic [63:0] st_fwd_data[2];
  logic [63:0] st_wb_data [2];

  logic [1:0]   rd_en_a;
  logic [9:0]   rd_addr_a;
  logic [63:0]  rd_data_a;
  logic         stall_a;
  logic [5:0]   pend_cnt_a;

  logic [2:0]   rd_en_b;
  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic         stall_b;
  logic [4:0]   pend_cnt_b;

  assign rd_en_a   = {st_rd_en[0][1], st_rd_en[0][0]};
  assign rd_addr_a = {st_rd_addr[0][1][4:0], st_rd_addr[0][0][4:0]};
  assign rd_en_b   = {st_rd_en[1][2], st_rd_en[1][1], st_rd_en[1][0]};
  assign rd_addr_b = {st_rd_addr[1][2][3:0], st_rd_addr[1][1][3:0], st_rd_addr[1][0][3:0]};

  mips_regfile_fwd #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk1(clk1), .rst(rst),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .fwd_valid(fwd_valid), .fwd_addr(st_fwd_addr[0][4:0]), .fwd_data(st_fwd_data[0][31:0]),
    .wb_en(wb_en), .wb_addr(st_wb_addr[0][4:0]), .wb_data(st_wb_data[0][31:0]),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_addr(st_issue_addr[0][4:0]),
    .flush(flush), .stall(stall_a), .pend_cnt(pend_cnt_a)
  );

  mips_regfile_fwd #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(1)) dut_b (
    .clk1(clk1), .rst(rst),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .fwd_valid(fwd_valid), .fwd_addr(st_fwd_addr[1][3:0]), .fwd_data(st_fwd_data[1]),
    .wb_en(wb_en), .wb_addr(st_wb_addr[1][3:0]), .wb_data(st_wb_data[1]),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_addr(st_issue_addr[1][3:0]),
    .flush(flush), .stall(stall_b), .pend_cnt(pend_cnt_b)
  );

  // Reference model state
  logic [63:0] mregs [2][32];
  bit          mpend [2][32];
  int          nreg_c [2] = '{32, 16};
  int          nrd_c  [2] = '{2, 3};
  logic [63:0] mask_c [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] expRead(input int c, input int a);
    if (a == 0)                                   return 64'd0;
    if (fwd_valid && int'(st_fwd_addr[c]) == a)   return st_fwd_data[c] & mask_c[c];
    if (wb_en && int'(st_wb_addr[c]) == a)        return st_wb_data[c] & mask_c[c];
    return mregs[c][a];
  endfunction

  function automatic bit expStall(input int c);
    for (int p = 0; p < nrd_c[c]; p++) begin
      int a = int'(st_rd_addr[c][p]);
      if (st_rd_en[c][p] && a != 0 && mpend[c][a] && !(wb_en && int'(st_wb_addr[c]) == a))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int pendCount(input int c);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mpend[c][r]);
    return n;
  endfunction

  // One clock cycle: check combinational outputs, advance the model, check pend_cnt
  task automatic applyStimulus();
    bit stl [2];
    logic [63:0] got;
    @(negedge clk1);
    #1;
    for (int c = 0; c < 2; c++) begin
      stl[c] = expStall(c);
      if (!rst) begin
        for (int p = 0; p < nrd_c[c]; p++) begin
          got = (c == 0) ? 64'(rd_data_a[p*32 +: 32]) : rd_data_b[p*64 +: 64];
          checkOutput($sformatf("c%0d_rd%0d", c, p), got, expRead(c, int'(st_rd_addr[c][p])));
        end
        checkOutput($sformatf("c%0d_stall", c), 64'((c == 0) ? stall_a : stall_b), 64'(stl[c]));
      end
    end
    @(posedge clk1);
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          mregs[c][r] = 64'd0;
          mpend[c][r] = 1'b0;
        end
      end else begin
        if (wb_en && st_wb_addr[c] != 0) mregs[c][st_wb_addr[c]] = st_wb_data[c] & mask_c[c];
        if (flush) begin
          for (int r = 0; r < 32; r++) mpend[c][r] = 1'b0;
        end else begin
          if (wb_en) mpend[c][st_wb_addr[c]] = 1'b0;
          if (issue_valid && issue_is_load && !stl[c] && st_issue_addr[c] != 0)
            mpend[c][st_issue_addr[c]] = 1'b1;
        end
      end
    end
    #1;
    checkOutput("c0_pend_cnt", 64'(pend_cnt_a), 64'(pendCount(0)));
    checkOutput("c1_pend_cnt", 64'(pend_cnt_b), 64'(pendCount(1)));
  endtask

  task automatic idle();
    rst = 0; fwd_valid = 0; wb_en = 0; issue_valid = 0; issue_is_load = 0; flush = 0;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 4; p++) begin
        st_rd_en[c][p] = 0;
        st_rd_addr[c][p] = 8'd0;
      end
      st_fwd_addr[c] = 8'd0; st_wb_addr[c] = 8'd0; st_issue_addr[c] = 8'd0;
      st_fwd_data[c] = 64'd0; st_wb_data[c] = 64'd0;
    end
  endtask

  task automatic setRead(input int p, input int a);
    for (int c = 0; c < 2; c++) begin
      st_rd_en[c][p] = 1'b1;
      st_rd_addr[c][p] = 8'(a);
    end
  endtask

  task automatic setWb(input int a, input logic [63:0] d);
    wb_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      st_wb_addr[c] = 8'(a);
      st_wb_data[c] = d;
    end
  endtask

  task automatic setFwd(input int a, input logic [63:0] d);
    fwd_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      st_fwd_addr[c] = 8'(a);
      st_fwd_data[c] = d;
    end
  endtask

  task automatic setIssue(input int a);
    issue_valid = 1'b1;
    issue_is_load = 1'b1;
    for (int c = 0; c < 2; c++) st_issue_addr[c] = 8'(a);
  endtask

  initial begin
    int plist [$];
    idle();
    rst = 1;
    applyStimulus();

    idle(); setRead(0, 5); setRead(1, 0); setRead(2, 5);
    applyStimulus();
    checkOutput("pcnt_after_reset", 64'(pend_cnt_a), 64'd0);

    idle(); setWb(3, 64'h1234_5678); setRead(0, 3);
    applyStimulus();
    idle(); setRead(0, 3); setRead(1, 3);
    applyStimulus();
    setFwd(3, 64'hAAAA_0000);
    applyStimulus();

    idle(); setWb(0, 64'hFFFF_FFFF_FFFF_FFFF); setFwd(0, 64'hFFFF_FFFF_FFFF_FFFF);
    setRead(0, 0); setRead(1, 0);
    applyStimulus();
    idle(); setRead(0, 0);
    applyStimulus();

    idle(); setIssue(7);
    applyStimulus();
    checkOutput("pcnt_load_r7", 64'(pend_cnt_a), 64'd1);
    idle(); setRead(0, 7);
    applyStimulus();
    idle(); setRead(0, 7); setWb(7, 64'h55);
    applyStimulus();
    checkOutput("pcnt_wb_r7", 64'(pend_cnt_a), 64'd0);

    idle(); setIssue(4); applyStimulus();
    idle(); setIssue(9); applyStimulus();
    checkOutput("pcnt_two_loads", 64'(pend_cnt_a), 64'd2);
    idle(); flush = 1; applyStimulus();
    checkOutput("pcnt_flush", 64'(pend_cnt_a), 64'd0);
    idle(); setRead(0, 4); setRead(1, 9); applyStimulus();
    idle(); flush = 1; setIssue(2); applyStimulus();
    checkOutput("pcnt_flush_issue", 64'(pend_cnt_a), 64'd0);

    idle(); setIssue(6); setWb(6, 64'h66); applyStimulus();
    checkOutput("pcnt_set_wins_a", 64'(pend_cnt_a), 64'd1);
    checkOutput("pcnt_set_wins_b", 64'(pend_cnt_b), 64'd1);
    idle(); setRead(0, 6); setRead(2, 6); applyStimulus();

    // Random traffic biased to low registers so hazards and bypasses collide often
    for (int n = 0; n < 600; n++) begin
      idle();
      rst           = ($urandom_range(0, 199) == 0);
      fwd_valid     = ($urandom_range(0, 3) == 0);
      wb_en         = ($urandom_range(0, 9) < 4);
      issue_valid   = ($urandom_range(0, 1) == 1);
      issue_is_load = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < 4; p++) begin
          st_rd_en[c][p]   = 1'($urandom_range(0, 1));
          st_rd_addr[c][p] = 8'($urandom_range(0, 7));
        end
        st_fwd_addr[c]   = 8'($urandom_range(0, 7));
        st_issue_addr[c] = 8'($urandom_range(0, 7));
        st_wb_addr[c]    = 8'($urandom_range(0, nreg_c[c] - 1));
        st_fwd_data[c]   = {$urandom, $urandom};
        st_wb_data[c]    = {$urandom, $urandom};
        plist.delete();
        for (int r = 0; r < 32; r++) if (mpend[c][r]) plist.push_back(r);
        if (plist.size() > 0 && $urandom_range(0, 1) == 1)
          st_wb_addr[c] = 8'(plist[$urandom_range(0, plist.size() - 1)]);
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
